// File: rtl/psum_accum_unit.sv
// Accumulates psum vectors over several passes into a local buffer, then drains shift/relu/saturate results.
// Inputs are accepted in ACCUM only; the drain holds its vector and index while out_ready is low.
module psum_accum_unit #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int out_bw  = 8,
    parameter int depth   = 16,
    localparam int aw     = $clog2(depth)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_start,
    input  logic [7:0]              cfg_passes,
    input  logic [aw:0]             cfg_len,
    input  logic                    cfg_relu,
    input  logic [4:0]              cfg_shift,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [psum_bw*col-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [out_bw*col-1:0]   out_data,
    output logic                    busy,
    output logic                    done
);
    localparam int acc_bw = psum_bw + 8;
    localparam logic [aw:0] LEN_MAX = (aw+1)'(depth);
    localparam logic signed [acc_bw-1:0] OMAX = acc_bw'((1 <<< (out_bw-1)) - 1);
    localparam logic signed [acc_bw-1:0] OMIN = acc_bw'(-(1 <<< (out_bw-1)));

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [aw-1:0]   idx_q, idx_d;
    logic [7:0]      pass_q, pass_d;
    logic            done_q, done_d;
    logic [7:0]      passes_q;
    logic [aw:0]     len_q;
    logic            relu_q;
    logic [4:0]      shift_q;
    logic [7:0]      passes_n;
    logic [aw:0]     len_n;
    logic            start, in_xfer, out_xfer, last_idx, last_pass;

    logic signed [acc_bw-1:0] acc_q [depth][col];
    logic signed [acc_bw-1:0] in_ext [col];
    logic signed [acc_bw-1:0] sh;

    assign start     = (state_q == IDLE) && cfg_start;
    assign in_xfer   = (state_q == ACCUM) && in_valid;
    assign out_xfer  = (state_q == DRAIN) && out_ready;
    assign last_idx  = ({1'b0, idx_q} == (len_q - 1'b1));
    assign last_pass = (pass_q == (passes_q - 8'd1));

    // Zero means one; oversized lengths clamp to the buffer size.
    assign passes_n = (cfg_passes == 8'd0) ? 8'd1 : cfg_passes;
    assign len_n    = (cfg_len == '0) ? (aw+1)'(1) :
                      (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = ACCUM;
                    idx_d   = '0;
                    pass_d  = '0;
                end
            end
            ACCUM: begin
                if (in_xfer) begin
                    if (last_idx) begin
                        idx_d  = '0;
                        pass_d = pass_q + 8'd1;
                        if (last_pass) state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_xfer) begin
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            pass_q   <= '0;
            done_q   <= 1'b0;
            passes_q <= 8'd1;
            len_q    <= (aw+1)'(1);
            relu_q   <= 1'b0;
            shift_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            if (start) begin
                passes_q <= passes_n;
                len_q    <= len_n;
                relu_q   <= cfg_relu;
                shift_q  <= cfg_shift;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < col; k++) begin
            in_ext[k] = {{(acc_bw-psum_bw){in_data[psum_bw*k+psum_bw-1]}},
                         in_data[psum_bw*k +: psum_bw]};
        end
    end

    // Accumulator storage carries no reset; only entries below len are written.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            for (int k = 0; k < col; k++) begin
                if (pass_q == 8'd0) acc_q[idx_q][k] <= in_ext[k];
                else                acc_q[idx_q][k] <= acc_q[idx_q][k] + in_ext[k];
            end
        end
    end

    always_comb begin
        out_data = '0;
        sh       = '0;
        for (int k = 0; k < col; k++) begin
            sh = acc_q[idx_q][k] >>> shift_q;
            if (relu_q && (sh < 0)) sh = '0;
            if (sh > OMAX)      sh = OMAX;
            else if (sh < OMIN) sh = OMIN;
            if (state_q == DRAIN) out_data[out_bw*k +: out_bw] = out_bw'(sh);
        end
    end
endmodule

// File: tb/tb_psum_accum_unit.sv
// Directed bench for psum_accum_unit: multi-pass sums, relu, saturation, stalls, config guarding and reset abort.
module tb_psum_accum_unit;
    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_start;
    logic [7:0]   cfg_passes;
    logic [4:0]   cfg_len;
    logic         cfg_relu;
    logic [4:0]   cfg_shift;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    psum_accum_unit dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_passes(cfg_passes),
        .cfg_len(cfg_len), .cfg_relu(cfg_relu), .cfg_shift(cfg_shift),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk16(input int a, input int b);
        logic [15:0] la, lb;
        logic [127:0] r;
        la = a[15:0];
        lb = b[15:0];
        r = '0;
        for (int k = 0; k < 8; k++) r[16*k +: 16] = (k % 2 == 0) ? la : lb;
        return r;
    endfunction

    function automatic logic [63:0] mk8(input int a, input int b);
        logic [7:0] la, lb;
        logic [63:0] r;
        la = a[7:0];
        lb = b[7:0];
        r = '0;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = (k % 2 == 0) ? la : lb;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int p, input int l, input logic r, input int s);
        cfg_passes = p[7:0];
        cfg_len    = l[4:0];
        cfg_relu   = r;
        cfg_shift  = s[4:0];
        cfg_start  = 1'b1;
        tick();
        cfg_start  = 1'b0;
    endtask

    task automatic push(input logic [127:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("push_timeout", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [63:0] exp);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check(tag, 128'(out_data), 128'(exp));
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_start = 1'b0; cfg_passes = '0; cfg_len = '0;
        cfg_relu = 1'b0; cfg_shift = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #22;
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        tick();
        reset = 1'b0;
        tick();
        check("idle_in_ready", 128'(in_ready), 128'(0));

        // Three passes of two vectors: 300 >>> 2 = 75 on every lane.
        start(3, 2, 1'b0, 2);
        check("t1_busy", 128'(busy), 128'(1));
        check("t1_in_ready", 128'(in_ready), 128'(1));
        for (int i = 0; i < 6; i++) push(mk16(100, 100));
        check("t1_drain_valid", 128'(out_valid), 128'(1));
        check("t1_drain_in_ready", 128'(in_ready), 128'(0));
        pop("t1_out0", mk8(75, 75));
        check("t1_done_early", 128'(done), 128'(0));
        pop("t1_out1", mk8(75, 75));
        check("t1_done", 128'(done), 128'(1));
        check("t1_idle_valid", 128'(out_valid), 128'(0));
        check("t1_idle_data", 128'(out_data), 128'(0));
        tick();
        check("t1_done_pulse", 128'(done), 128'(0));

        // Single negative lane, with and without relu.
        start(1, 1, 1'b0, 0);
        push({112'd0, 16'hFFCE});
        pop("t2_neg", {56'd0, 8'hCE});
        start(1, 1, 1'b1, 0);
        push({112'd0, 16'hFFCE});
        pop("t2_relu", 64'd0);

        // Four passes of +/-1000 saturate to the output range.
        start(4, 1, 1'b0, 0);
        for (int i = 0; i < 4; i++) push(mk16(1000, -1000));
        pop("t3_sat", mk8(127, -128));

        // Drain stall: data and index hold while out_ready is low.
        start(1, 2, 1'b0, 0);
        push(mk16(5, 5));
        push(mk16(-7, -7));
        for (int i = 0; i < 3; i++) begin
            check("t4_stall_valid", 128'(out_valid), 128'(1));
            check("t4_stall_data", 128'(out_data), 128'(mk8(5, 5)));
            tick();
        end
        pop("t4_out0", mk8(5, 5));
        pop("t4_out1", mk8(-7, -7));
        check("t4_done", 128'(done), 128'(1));

        // A mid-job start with different config must be ignored.
        tick();
        start(2, 2, 1'b0, 1);
        push(mk16(10, 10));
        cfg_passes = 8'd1; cfg_len = 5'd1; cfg_relu = 1'b1; cfg_shift = 5'd0; cfg_start = 1'b1;
        push(mk16(-20, -20));
        cfg_start = 1'b0;
        push(mk16(30, 30));
        check("t5_still_accum", 128'(in_ready), 128'(1));
        push(mk16(-40, -40));
        pop("t5_out0", mk8(20, 20));
        pop("t5_out1", mk8(-30, -30));
        check("t5_done", 128'(done), 128'(1));
        // Start on the done cycle; zero passes and length act as one.
        start(0, 0, 1'b0, 0);
        check("t5_restart_busy", 128'(busy), 128'(1));
        check("t5_restart_done", 128'(done), 128'(0));
        push(mk16(9, -9));
        check("t5_len1_drain", 128'(out_valid), 128'(1));
        pop("t5_len1_out", mk8(9, -9));
        check("t5_len1_done", 128'(done), 128'(1));

        // Reset mid-job aborts without done.
        start(1, 4, 1'b0, 0);
        for (int i = 0; i < 3; i++) push(mk16(1, 1));
        #2;
        reset = 1'b1;
        #1;
        check("t6_busy", 128'(busy), 128'(0));
        check("t6_in_ready", 128'(in_ready), 128'(0));
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t6_no_done", 128'(done), 128'(0));
            check("t6_stay_idle", 128'(busy), 128'(0));
            tick();
        end
        start(2, 1, 1'b0, 0);
        push(mk16(3, -3));
        push(mk16(4, -4));
        pop("t6_new_job", mk8(7, -7));
        check("t6_new_done", 128'(done), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/psum_accum_unit.md
PSUM_ACCUM_UNIT -- requirements
Module: psum_accum_unit

Interface
REQ-001 Parameter col, default 8: number of psum lanes per vector.
REQ-002 Parameter psum_bw, default 16: signed input psum width per lane.
REQ-003 Parameter out_bw, default 8: signed output width per lane.
REQ-004 Parameter depth, default 16: accumulator entries (vectors per pass); power of two, at least 2.
REQ-005 Derived: aw = clog2(depth); acc_bw = psum_bw+8 (a guaranteed no-overflow bound for 255 passes).
REQ-006 One clock; reset is asynchronous and active-high.
REQ-007 Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- cfg_start  in  1  job start pulse; sampled only in IDLE.
- cfg_passes  in  8  accumulation passes; 0 is treated as 1.
- cfg_len  in  aw+1  vectors per pass; 0 is treated as 1, values above depth clamp to depth.
- cfg_relu  in  1  1 = clamp negative results to 0.
- cfg_shift  in  5  arithmetic right shift applied before output.
- in_valid  in  1  input vector valid.
- in_ready  out  1  unit accepts an input vector.
- in_data  in  psum_bw*col  psum vector; lane k occupies bits [psum_bw*(k+1)-1 : psum_bw*k].
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts the output vector.
- out_data  out  out_bw*col  post-processed vector, same lane packing as in_data.
- busy  out  1  high when the FSM is not in IDLE.
- done  out  1  one-cycle pulse after the last output transfer.

Function
REQ-008 The FSM shall have three states, IDLE, ACCUM and DRAIN, and shall leave reset in IDLE.
REQ-009 IDLE: on cfg_start=1, the unit shall latch passes, len, relu and shift (after normalisation), clear idx and pass, and enter ACCUM on the next cycle.
REQ-010 in_ready shall be 1 only in ACCUM; an input transfer occurs on a cycle with in_valid=1 and in_ready=1.
REQ-011 On transfer in pass 0: acc[idx] <= sign-extended in_data, per lane.
REQ-012 On transfer in pass >0: acc[idx] <= acc[idx] + sign-extended in_data, per lane, at acc_bw width (no wrap possible).
REQ-013 After each transfer idx shall increment; when idx == len-1, idx shall return to 0 and pass shall increment.
REQ-014 If pass == passes-1 at that point, the FSM shall enter DRAIN on the next cycle.
REQ-015 DRAIN: out_valid=1, and out_data = post(acc[idx]), driven combinationally from the registered entry.
REQ-016 In DRAIN, an output transfer on out_valid=1 and out_ready=1 shall increment idx; the transfer at idx == len-1 shall return the FSM to IDLE, with done=1 for exactly that next cycle.
REQ-017 While out_ready=0, out_data and idx shall hold.
REQ-018 post(), per lane, in order:
- arithmetic right shift by shift (truncation toward negative infinity);
- if relu=1, negative values become 0;
- saturate to the signed out_bw range [-2^(out_bw-1), 2^(out_bw-1)-1].
REQ-019 cfg_start shall be ignored in ACCUM and DRAIN; the latched configuration shall not change mid-job.
REQ-020 A cfg_start in the same cycle as done=1 is accepted, because the FSM is already in IDLE.
REQ-021 acc entries at or above len shall be untouched by a job.
REQ-022 The first out_valid shall rise exactly one cycle after the final input transfer.
REQ-023 Minimum job time shall be 1 + passes*len + len cycles with no stalls.

Reset
REQ-024 On reset, asynchronously: state=IDLE, idx=0, pass=0, in_ready=0, out_valid=0, busy=0, done=0, out_data=0.
REQ-025 acc contents need not be reset; out_data shall read 0 whenever out_valid=0.
REQ-026 A reset asserted mid-ACCUM or mid-DRAIN shall abort the job with no done pulse; the next job shall need a new cfg_start.

Verification
REQ-027 passes=3, len=2, shift=2, relu=0, every lane input 100 on all 6 transfers -> 2 outputs, every lane 75; done one cycle after the 2nd output transfer.
REQ-028 passes=1, len=1, lane0=-50, relu=0 -> lane0=-50 (8'hCE); repeat with relu=1 -> lane0=0.
REQ-029 passes=4, len=1, lane input 1000, shift=0 -> lane output 127 (saturated); input -1000 -> -128.
REQ-030 DRAIN with out_ready=0 for 3 cycles -> out_valid stays 1, out_data stable, idx unchanged; then one transfer per ready cycle.
REQ-031 cfg_start pulsed mid-ACCUM with different cfg -> ignored, original job completes as configured; cfg_passes=0 and cfg_len=0 behave as 1.
REQ-032 reset pulsed after 3 transfers of a len=4 job -> busy=0 and in_ready=0 immediately, no done; a new job then runs correctly.
